// File: rtl/uart_tx_sched_pkg.sv
// Shared types for the UART transmit scheduler: FSM state encoding, source IDs
// and the width of the per-request byte counter.
package uart_tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO
    } sched_state_t;

    typedef enum logic {
        SRC_ALU,
        SRC_RF
    } src_id_t;

    localparam int BCNT_W = 2;

    // ALU results go out as two bytes, register-file reads as one.
    function automatic logic [BCNT_W-1:0] bytes_for_src(input src_id_t src);
        return (src == SRC_ALU) ? BCNT_W'(2) : BCNT_W'(1);
    endfunction

endpackage

// File: rtl/uart_tx_req_slot.sv
// One-deep request slot: pending bit, data register and overflow detection.
// A strobe arriving in the same cycle the slot is consumed is accepted.
module uart_tx_req_slot
    import uart_tx_sched_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             consume,
    output logic             pending,
    output logic             pending_next,
    output logic [WIDTH-1:0] data,
    output logic             overflow_event
);

    logic accept;

    always_comb begin
        accept         = load_valid && (!pending || consume);
        overflow_event = load_valid && pending && !consume;
        pending_next   = accept || (pending && !consume);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending <= 1'b0;
            data    <= '0;
        end else begin
            pending <= pending_next;
            if (accept) begin
                data <= load_data;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Shares one UART transmitter between ALU results (two bytes, low first) and
// register-file reads (one byte). Optional WAIT_HI watchdog: UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler
    import uart_tx_sched_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int TIMEOUT_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [2*DATA_WIDTH-1:0] alu_result,
    input  logic                    alu_result_valid,
    input  logic [DATA_WIDTH-1:0]   rf_read_data,
    input  logic                    rf_read_data_valid,
    input  logic                    tx_busy,
    output logic                    tx_data_valid,
    output logic [DATA_WIDTH-1:0]   tx_parallel_data,
    output logic                    sched_busy,
`ifdef UART_TX_SCHED_TIMEOUT_EN
    output logic                    timeout_err,
`endif
    output logic                    overflow
);

    sched_state_t state, next_state;
    logic [BCNT_W-1:0]       byte_cnt, byte_cnt_next;
    logic [2*DATA_WIDTH-1:0] hold, hold_next;
    logic                    data_valid_next;
    logic [DATA_WIDTH-1:0]   parallel_data_next;

    logic                    alu_pending, alu_pending_next, alu_consume, alu_ovf;
    logic [2*DATA_WIDTH-1:0] alu_data;
    logic                    rf_pending, rf_pending_next, rf_consume, rf_ovf;
    logic [DATA_WIDTH-1:0]   rf_data;

`ifdef UART_TX_SCHED_TIMEOUT_EN
    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    logic [TO_W-1:0] to_cnt, to_cnt_next;
    logic            timeout_next;
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
`endif

    uart_tx_req_slot #(.WIDTH(2*DATA_WIDTH)) u_alu_slot (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (alu_result_valid),
        .load_data      (alu_result),
        .consume        (alu_consume),
        .pending        (alu_pending),
        .pending_next   (alu_pending_next),
        .data           (alu_data),
        .overflow_event (alu_ovf)
    );

    uart_tx_req_slot #(.WIDTH(DATA_WIDTH)) u_rf_slot (
        .clk            (clk),
        .reset          (reset),
        .load_valid     (rf_read_data_valid),
        .load_data      (rf_read_data),
        .consume        (rf_consume),
        .pending        (rf_pending),
        .pending_next   (rf_pending_next),
        .data           (rf_data),
        .overflow_event (rf_ovf)
    );

    // Next-state logic; the outputs are computed here and registered below so
    // tx_data_valid lines up exactly with the SEND state.
    always_comb begin
        next_state         = state;
        byte_cnt_next      = byte_cnt;
        hold_next          = hold;
        data_valid_next    = 1'b0;
        parallel_data_next = tx_parallel_data;
        alu_consume        = 1'b0;
        rf_consume         = 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
        to_cnt_next        = '0;
        timeout_next       = timeout_err;
`endif
        unique case (state)
            ST_IDLE: begin
                if (alu_pending) begin
                    alu_consume        = 1'b1;
                    hold_next          = alu_data;
                    byte_cnt_next      = bytes_for_src(SRC_ALU);
                    data_valid_next    = 1'b1;
                    parallel_data_next = alu_data[DATA_WIDTH-1:0];
                    next_state         = ST_SEND;
                end else if (rf_pending) begin
                    rf_consume         = 1'b1;
                    hold_next          = {{DATA_WIDTH{1'b0}}, rf_data};
                    byte_cnt_next      = bytes_for_src(SRC_RF);
                    data_valid_next    = 1'b1;
                    parallel_data_next = rf_data;
                    next_state         = ST_SEND;
                end
            end
            ST_SEND: begin
                next_state = ST_WAIT_HI;
            end
            ST_WAIT_HI: begin
                if (tx_busy) begin
                    next_state = ST_WAIT_LO;
                end
`ifdef UART_TX_SCHED_TIMEOUT_EN
                else if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    next_state    = ST_IDLE;
                    byte_cnt_next = '0;
                    timeout_next  = 1'b1;
                end else begin
                    to_cnt_next = to_cnt + 1'b1;
                end
`endif
            end
            ST_WAIT_LO: begin
                if (!tx_busy) begin
                    if (byte_cnt > BCNT_W'(1)) begin
                        byte_cnt_next      = byte_cnt - 1'b1;
                        hold_next          = hold >> DATA_WIDTH;
                        data_valid_next    = 1'b1;
                        parallel_data_next = hold[2*DATA_WIDTH-1:DATA_WIDTH];
                        next_state         = ST_SEND;
                    end else begin
                        byte_cnt_next = '0;
                        next_state    = ST_IDLE;
                    end
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= ST_IDLE;
            byte_cnt         <= '0;
            hold             <= '0;
            tx_data_valid    <= 1'b0;
            tx_parallel_data <= '0;
            sched_busy       <= 1'b0;
            overflow         <= 1'b0;
        end else begin
            state            <= next_state;
            byte_cnt         <= byte_cnt_next;
            hold             <= hold_next;
            tx_data_valid    <= data_valid_next;
            tx_parallel_data <= parallel_data_next;
            sched_busy       <= (next_state != ST_IDLE) || alu_pending_next || rf_pending_next;
            overflow         <= overflow || alu_ovf || rf_ovf;
        end
    end

`ifdef UART_TX_SCHED_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            to_cnt      <= '0;
            timeout_err <= 1'b0;
        end else begin
            to_cnt      <= to_cnt_next;
            timeout_err <= timeout_next;
        end
    end
`endif

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Self-checking bench for uart_tx_scheduler: vector table, hand-written corner
// sequences and randomized requests against a byte-stream model.
module tb_uart_tx_scheduler;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset;
    logic [2*DW-1:0] alu_result;
    logic          alu_result_valid;
    logic [DW-1:0] rf_read_data;
    logic          rf_read_data_valid;
    logic          tx_busy = 1'b0;
    logic          tx_data_valid;
    logic [DW-1:0] tx_parallel_data;
    logic          sched_busy;
    logic          overflow;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    logic          timeout_err;
`endif

    int checks = 0;
    int errors = 0;

    logic [7:0] seen_q[$];
    logic [7:0] exp_q[$];

    int busy_len     = 11;
    int busy_left    = 0;
    int ignore_dv    = 0;
    bit raise_pending = 1'b0;

    typedef struct {
        logic        av;
        logic [15:0] a;
        logic        rv;
        logic [7:0]  r;
        int          busy;
        int          nexp;
        logic [7:0]  e0;
        logic [7:0]  e1;
        logic [7:0]  e2;
    } vec_t;

    vec_t vecs[5];

    uart_tx_scheduler #(.DATA_WIDTH(DW), .TIMEOUT_CYCLES(4)) dut (
        .clk                (clk),
        .reset              (reset),
        .alu_result         (alu_result),
        .alu_result_valid   (alu_result_valid),
        .rf_read_data       (rf_read_data),
        .rf_read_data_valid (rf_read_data_valid),
        .tx_busy            (tx_busy),
        .tx_data_valid      (tx_data_valid),
        .tx_parallel_data   (tx_parallel_data),
        .sched_busy         (sched_busy),
`ifdef UART_TX_SCHED_TIMEOUT_EN
        .timeout_err        (timeout_err),
`endif
        .overflow           (overflow)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises one cycle after each data_valid pulse and
    // stays high for busy_len cycles; every issued byte is logged.
    always @(negedge clk) begin
        if (raise_pending) begin
            raise_pending = 1'b0;
            tx_busy       = 1'b1;
            busy_left     = busy_len;
        end else if (busy_left > 0) begin
            busy_left--;
            if (busy_left == 0) tx_busy = 1'b0;
        end
        if (tx_data_valid === 1'b1) begin
            seen_q.push_back(tx_parallel_data);
            if (ignore_dv > 0) ignore_dv--;
            else raise_pending = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL global_timeout actual=running required=finished");
        $fatal(1, "[TB] simulation time limit");
    end

    task automatic check_value(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name);
        check_value({name, "_count"}, seen_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            check_value($sformatf("%s_byte%0d", name, i),
                        (i < seen_q.size()) ? {24'h0, seen_q[i]} : 32'hDEAD, {24'h0, exp_q[i]});
        end
        seen_q.delete();
        exp_q.delete();
    endtask

    task automatic apply_stimulus(input logic av, input logic [15:0] a, input logic rv, input logic [7:0] r);
        @(negedge clk);
        alu_result_valid   = av;
        alu_result         = a;
        rf_read_data_valid = rv;
        rf_read_data       = r;
        @(negedge clk);
        alu_result_valid   = 1'b0;
        rf_read_data_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (sched_busy === 1'b1 && n < 400) begin
            @(posedge clk); #2;
            n++;
        end
        if (sched_busy !== 1'b0) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_wait_idle actual=%0b required=0", name, sched_busy);
        end
    endtask

    task automatic wait_busy(input logic level, input string name);
        int n = 0;
        while (tx_busy !== level && n < 60) begin
            @(posedge clk); #2;
            n++;
        end
        if (tx_busy !== level) begin
            checks++;
            errors++;
            $display("[TB] FAIL %s_wait_tx_busy actual=%0b required=%0b", name, tx_busy, level);
        end
    endtask

    initial begin
        vecs[0] = '{1'b0, 16'h0000, 1'b1, 8'hA5, 11, 1, 8'hA5, 8'h00, 8'h00};
        vecs[1] = '{1'b1, 16'hBEEF, 1'b0, 8'h00, 11, 2, 8'hEF, 8'hBE, 8'h00};
        vecs[2] = '{1'b1, 16'h1234, 1'b1, 8'h56, 3,  3, 8'h34, 8'h12, 8'h56};
        vecs[3] = '{1'b0, 16'h0000, 1'b1, 8'h00, 1,  1, 8'h00, 8'h00, 8'h00};
        vecs[4] = '{1'b1, 16'hFF00, 1'b1, 8'h80, 6,  3, 8'h00, 8'hFF, 8'h80};

        reset              = 1'b1;
        alu_result         = '0;
        alu_result_valid   = 1'b0;
        rf_read_data       = '0;
        rf_read_data_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_value("reset_tx_data_valid", tx_data_valid, 0);
        check_value("reset_tx_parallel_data", tx_parallel_data, 0);
        check_value("reset_sched_busy", sched_busy, 0);
        check_value("reset_overflow", overflow, 0);
`ifdef UART_TX_SCHED_TIMEOUT_EN
        check_value("reset_timeout_err", timeout_err, 0);
`endif
        @(negedge clk);
        reset = 1'b0;

        // RF 0xA5: exact strobe-to-pulse latency and sched_busy fall
        busy_len = 11;
        @(negedge clk);
        rf_read_data_valid = 1'b1;
        rf_read_data       = 8'hA5;
        @(posedge clk); #1;
        check_value("a5_sched_busy_rise", sched_busy, 1);
        check_value("a5_dv_edge_k", tx_data_valid, 0);
        @(negedge clk);
        rf_read_data_valid = 1'b0;
        @(posedge clk); #1;
        check_value("a5_dv_edge_k1", tx_data_valid, 1);
        check_value("a5_data", tx_parallel_data, 8'hA5);
        @(posedge clk); #1;
        check_value("a5_dv_edge_k2", tx_data_valid, 0);
        wait_busy(1'b1, "a5");
        wait_busy(1'b0, "a5");
        check_value("a5_sched_busy_fall", sched_busy, 0);
        check_value("a5_hold_data", tx_parallel_data, 8'hA5);
        exp_q.push_back(8'hA5);
        check_output("a5_stream");

        // Vector table
        for (int i = 0; i < 5; i++) begin
            busy_len = vecs[i].busy;
            apply_stimulus(vecs[i].av, vecs[i].a, vecs[i].rv, vecs[i].r);
            wait_idle($sformatf("vec%0d", i));
            exp_q.push_back(vecs[i].e0);
            if (vecs[i].nexp > 1) exp_q.push_back(vecs[i].e1);
            if (vecs[i].nexp > 2) exp_q.push_back(vecs[i].e2);
            check_output($sformatf("vec%0d", i));
            check_value($sformatf("vec%0d_overflow", i), overflow, 0);
        end

        // ALU 0xBEEF: second byte issued one edge after busy falls
        busy_len = 5;
        apply_stimulus(1'b1, 16'hBEEF, 1'b0, 8'h00);
        wait_busy(1'b1, "gap");
        wait_busy(1'b0, "gap");
        check_value("gap_second_dv", tx_data_valid, 1);
        check_value("gap_second_byte", tx_parallel_data, 8'hBE);
        wait_idle("gap");
        exp_q.push_back(8'hEF);
        exp_q.push_back(8'hBE);
        check_output("gap_stream");

        // RF strobe landing in the consume cycle is accepted
        busy_len = 4;
        @(negedge clk);
        rf_read_data_valid = 1'b1;
        rf_read_data       = 8'h33;
        @(negedge clk);
        rf_read_data       = 8'h44;
        @(posedge clk); #1;
        check_value("consume_cycle_overflow", overflow, 0);
        check_value("consume_cycle_first", tx_parallel_data, 8'h33);
        @(negedge clk);
        rf_read_data_valid = 1'b0;
        wait_idle("consume");
        exp_q.push_back(8'h33);
        exp_q.push_back(8'h44);
        check_output("consume_stream");
        check_value("consume_overflow_end", overflow, 0);

        // Second RF strobe on a full, unconsumed slot is dropped
        busy_len = 4;
        @(negedge clk);
        alu_result_valid = 1'b1;
        alu_result       = 16'h0102;
        @(negedge clk);
        alu_result_valid   = 1'b0;
        rf_read_data_valid = 1'b1;
        rf_read_data       = 8'h11;
        @(posedge clk); #1;
        check_value("ovf_before_drop", overflow, 0);
        @(negedge clk);
        rf_read_data = 8'h22;
        @(posedge clk); #1;
        check_value("ovf_on_drop", overflow, 1);
        @(negedge clk);
        rf_read_data_valid = 1'b0;
        wait_idle("ovf");
        exp_q.push_back(8'h02);
        exp_q.push_back(8'h01);
        exp_q.push_back(8'h11);
        check_output("ovf_stream");
        check_value("ovf_sticky", overflow, 1);

        // Reset while waiting for busy to fall on the second ALU byte
        busy_len = 6;
        apply_stimulus(1'b1, 16'hCAFE, 1'b0, 8'h00);
        begin
            int n = 0;
            while (seen_q.size() < 2 && n < 80) begin
                @(posedge clk); #2;
                n++;
            end
        end
        check_value("midrst_second_issued", seen_q.size(), 2);
        wait_busy(1'b1, "midrst");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check_value("midrst_dv", tx_data_valid, 0);
        check_value("midrst_data", tx_parallel_data, 0);
        check_value("midrst_sched_busy", sched_busy, 0);
        check_value("midrst_overflow", overflow, 0);
        @(negedge clk);
        reset = 1'b0;
        seen_q.delete();
        repeat (30) @(posedge clk);
        #1;
        check_value("midrst_no_more_bytes", seen_q.size(), 0);
        check_value("midrst_idle", sched_busy, 0);
        wait_busy(1'b0, "midrst_tx_done");

        // Randomized requests against the byte-stream model
        for (int it = 0; it < 20; it++) begin
            int          sel;
            logic [15:0] a;
            logic [7:0]  r;
            sel      = $urandom_range(1, 3);
            a        = 16'($urandom);
            r        = 8'($urandom);
            busy_len = $urandom_range(1, 14);
            apply_stimulus(sel[0], a, sel[1], r);
            if (sel[0]) begin
                exp_q.push_back(a[7:0]);
                exp_q.push_back(a[15:8]);
            end
            if (sel[1]) exp_q.push_back(r);
            wait_idle($sformatf("rand%0d", it));
            check_output($sformatf("rand%0d", it));
        end
        check_value("rand_overflow", overflow, 0);

`ifdef UART_TX_SCHED_TIMEOUT_EN
        // Transmitter ignores the first byte: watchdog drops the rest of the ALU request
        busy_len  = 3;
        ignore_dv = 1;
        @(negedge clk);
        alu_result_valid   = 1'b1;
        alu_result         = 16'hABCD;
        rf_read_data_valid = 1'b1;
        rf_read_data       = 8'h77;
        @(posedge clk); #1;
        @(negedge clk);
        alu_result_valid   = 1'b0;
        rf_read_data_valid = 1'b0;
        @(posedge clk); #1;
        check_value("to_first_dv", tx_data_valid, 1);
        check_value("to_first_byte", tx_parallel_data, 8'hCD);
        repeat (4) @(posedge clk);
        #1;
        check_value("to_err_before", timeout_err, 0);
        @(posedge clk); #1;
        check_value("to_err_set", timeout_err, 1);
        wait_idle("to");
        exp_q.push_back(8'hCD);
        exp_q.push_back(8'h77);
        check_output("to_stream");
        check_value("to_err_sticky", timeout_err, 1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_tx_scheduler.md
# uart_tx_scheduler

- Shares the single UART transmitter between two result sources: the ALU (2·DATA_WIDTH-bit result) and the register file (DATA_WIDTH-bit read data).
- Holds one pending request per source and arbitrates between them with fixed priority.
- Splits the ALU word into two bytes and drives the transmitter's data_valid/parallel_data handshake, pacing each byte on the transmitter's busy flag.
- Sits between the system controller datapath and the UART transmitter, in the same clock domain.

## Interface
Parameters:
- DATA_WIDTH, 8, width of one UART frame payload
- TIMEOUT_CYCLES, 4, cycles to wait for tx_busy to rise after a byte is issued (used only with UART_TX_SCHED_TIMEOUT_EN)

Ports:
- Clock and reset: one clock; reset is synchronous and active-high (ports named clk and reset).
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- alu_result  input  2·DATA_WIDTH  ALU result word
- alu_result_valid  input  1  one-cycle strobe; alu_result valid
- rf_read_data  input  DATA_WIDTH  register-file read data
- rf_read_data_valid  input  1  one-cycle strobe; rf_read_data valid
- tx_busy  input  1  busy flag from the UART transmitter
- tx_data_valid  output  1  one-cycle strobe to the transmitter
- tx_parallel_data  output  DATA_WIDTH  byte presented to the transmitter
- sched_busy  output  1  any request pending or FSM not IDLE
- overflow  output  1  sticky: a request arrived while that source's slot was already full
- timeout_err  output  1  sticky watchdog flag; exists only with UART_TX_SCHED_TIMEOUT_EN

## Operation
- Request slots: one per source, each with a pending bit and data register.
  - A valid strobe loads the slot when it is empty.
  - A strobe also loads the slot in the same cycle the FSM consumes it; this is not an overflow.
  - A strobe on a full slot that is not being consumed is dropped and sets overflow.
- Arbitration happens in IDLE only. ALU has priority over RF.
  - Consuming a slot clears its pending bit and copies its data into the FSM hold register.
  - Byte count is 2 for ALU, 1 for RF.
- FSM states: IDLE, SEND, WAIT_HI, WAIT_LO.
  - IDLE → SEND when any slot is pending.
  - SEND: tx_data_valid = 1 for exactly one cycle; tx_parallel_data = current byte. Next state WAIT_HI.
  - WAIT_HI: stay until tx_busy = 1, then go to WAIT_LO.
  - WAIT_LO: stay until tx_busy = 0. Then decrement the byte count. If bytes remain, go to SEND with the next byte; otherwise go to IDLE.
- Byte order for ALU: alu_result[DATA_WIDTH-1:0] first, then alu_result[2·DATA_WIDTH-1:DATA_WIDTH].
- tx_parallel_data holds the last issued byte outside SEND; it never glitches while tx_busy = 1.
- Reset mid-operation: all slots and the FSM clear. A frame already in flight is abandoned; the transmitter completes it on its own.

## Timing
- Reset values: tx_data_valid 0, tx_parallel_data 0, sched_busy 0, overflow 0, timeout_err 0, FSM IDLE, slots empty.
- All outputs are registered.
- Strobe sampled in IDLE at edge k → slot loaded at edge k, SEND entered at edge k+1. tx_data_valid is high for cycle k+1..k+2.
- sched_busy rises at edge k and falls at the edge where the FSM returns to IDLE with both slots empty.
- Minimum gap between consecutive bytes: the edge tx_busy is seen low → next tx_data_valid one edge later.
- Simultaneous ALU and RF strobes in IDLE: both are captured. ALU is sent first; RF follows immediately after ALU completes.

## Configuration
- UART_TX_SCHED_TIMEOUT_EN defined:
  - A counter runs in WAIT_HI.
  - If tx_busy has not risen after TIMEOUT_CYCLES cycles, the FSM returns to IDLE, drops the remaining bytes of that request, and sets timeout_err (sticky until reset).
- Not defined: no counter and no timeout_err port. WAIT_HI waits indefinitely.

## Structure
- Shared package (uart_tx_sched_pkg): FSM state encoding, source IDs (SRC_ALU, SRC_RF), byte-count width.
- One sub-module: uart_tx_req_slot, parameterised data width.
  - Contains the pending bit, data register and overflow detect.
  - Instantiated twice: width 2·DATA_WIDTH for ALU, DATA_WIDTH for RF.

## Test plan
- RF strobe with 0xA5, transmitter model raises busy 1 cycle after data_valid for 11 cycles → one tx_data_valid pulse with 0xA5 two edges after the strobe; sched_busy falls after busy drops.
- ALU strobe with 0xBEEF → two pulses: 0xEF, then 0xBE. The second pulse is issued one edge after busy falls.
- ALU 0x1234 and RF 0x56 strobed in the same cycle → bytes 0x34, 0x12, 0x56 in that order; overflow stays 0.
- RF 0x11 strobed, then RF 0x22 while 0x11 is still pending in its slot, unconsumed → 0x22 dropped, overflow = 1 and stays 1. Strobe arriving in the consume cycle → accepted, overflow 0.
- Reset asserted during WAIT_LO of the second ALU byte → next edge: all outputs 0, FSM IDLE, nothing further issued.
- With UART_TX_SCHED_TIMEOUT_EN, tx_busy held 0 → after 4 WAIT_HI cycles timeout_err = 1, FSM IDLE, next pending request served normally.
